// File: rtl/tone_sequencer_pkg.sv
// Shared types and constants for the tone sequencer: FSM state encoding,
// step-table record, the built-in default step table and a clog2 helper.
package tone_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_PLAY   = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // The default table is authored for 2 channels of 8-bit half-periods.
    // Wider builds reuse its columns and rows modulo these sizes.
    localparam int TBL_CH    = 2;
    localparam int TBL_STEPS = 5;

    typedef struct packed {
        logic [0:TBL_CH-1][7:0] freq;  // freq[0] is channel 0
        logic [7:0]             dur;   // step length in prescaler ticks
    } step_t;

    localparam step_t DEF_TABLE [TBL_STEPS] = '{
        '{freq: '{8'd20, 8'd20}, dur: 8'd20},
        '{freq: '{8'd5,  8'd20}, dur: 8'd6},
        '{freq: '{8'd1,  8'd20}, dur: 8'd4},
        '{freq: '{8'd24, 8'd20}, dur: 8'd2},
        '{freq: '{8'd20, 8'd20}, dur: 8'd1}
    };

    // Ceiling log2, never below 1 so it can size a vector directly.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/tone_sequencer_tick_prescaler.sv
// Divides the clock into one-cycle tick pulses every TICK_DIV cycles.
// The synchronous clear holds the phase at zero so a step starts on a
// whole tick boundary.
module tick_prescaler
    import tone_seq_pkg::*;
#(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_MAX);

    // Free-running modulo-TICK_DIV phase counter
    always_ff @(posedge clk) begin
        if (reset || clear || tick) cnt <= '0;
        else                        cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/tone_sequencer.sv
// Tone sequencer: produces per-channel half-period values for downstream
// square-wave generators. A zero switch plays the built-in step table,
// a nonzero switch drives every channel with the switch value.
// Build option SEQ_LOOP_EN: the table wraps to step 0 instead of stopping
// in HOLD (done is then constant 0).
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int FREQ_W   = 8,
    parameter int SW_W     = 4,
    parameter int STEPS    = 5,
    parameter int DUR_W    = 8,
    parameter int TICK_DIV = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SW_W-1:0]          switch,
    output logic [NUM_CH*FREQ_W-1:0] freq,
    output logic                     freq_update,
    output logic                     playing,
    output logic [clog2(STEPS)-1:0]  step_idx,
    output logic                     done
);

    localparam int IDX_W = clog2(STEPS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(STEPS - 1);

    state_t                         state, state_nxt;
    logic [SW_W-1:0]                sw_q;
    logic                           armed;     // sw_q holds a real sample
    logic [NUM_CH-1:0][FREQ_W-1:0]  freq_q, freq_nxt, manual_f;
    logic [IDX_W-1:0]               idx_q, idx_nxt, idx_inc;
    logic [DUR_W-1:0]               dur_cnt, dur_nxt;
    logic                           tick;

    logic [NUM_CH-1:0][FREQ_W-1:0]  tbl_f [STEPS];
    logic [DUR_W-1:0]               tbl_d [STEPS];

    // Constant step table resized to this build; zero durations count as 1
    always_comb begin
        for (int k = 0; k < STEPS; k++) begin
            if (DEF_TABLE[k % TBL_STEPS].dur == 8'd0)
                tbl_d[k] = DUR_W'(1);
            else
                tbl_d[k] = DUR_W'(DEF_TABLE[k % TBL_STEPS].dur);
            for (int c = 0; c < NUM_CH; c++)
                tbl_f[k][c] = FREQ_W'(DEF_TABLE[k % TBL_STEPS].freq[c % TBL_CH]);
        end
    end

    // Manual value on every channel, zero-extended or LSB-truncated
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) manual_f[c] = FREQ_W'(sw_q);
    end

    assign idx_inc = idx_q + 1'b1;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk   (clk),
        .reset (reset),
        .clear (state != ST_PLAY),
        .tick  (tick)
    );

    // Next-state, next-freq and step bookkeeping
    always_comb begin
        state_nxt = state;
        freq_nxt  = freq_q;
        idx_nxt   = idx_q;
        dur_nxt   = dur_cnt;
        case (state)
            ST_IDLE: begin
                if (armed) begin
                    if (sw_q == '0) begin
                        state_nxt = ST_PLAY;
                        freq_nxt  = tbl_f[0];
                    end else begin
                        state_nxt = ST_MANUAL;
                        freq_nxt  = manual_f;
                    end
                end
            end
            ST_MANUAL: begin
                if (sw_q == '0) begin
                    state_nxt = ST_PLAY;
                    idx_nxt   = '0;
                    dur_nxt   = '0;
                    freq_nxt  = tbl_f[0];
                end else begin
                    freq_nxt  = manual_f;
                end
            end
            ST_PLAY: begin
                if (sw_q != '0) begin
                    state_nxt = ST_MANUAL;
                    freq_nxt  = manual_f;
                    idx_nxt   = '0;
                    dur_nxt   = '0;
                end else if (tick) begin
                    if (dur_cnt == tbl_d[idx_q] - DUR_W'(1)) begin
                        dur_nxt = '0;
                        if (idx_q == LAST) begin
`ifdef SEQ_LOOP_EN
                            idx_nxt  = '0;
                            freq_nxt = tbl_f[0];
`else
                            state_nxt = ST_HOLD;
                            idx_nxt   = '0;
`endif
                        end else begin
                            idx_nxt  = idx_inc;
                            freq_nxt = tbl_f[idx_inc];
                        end
                    end else begin
                        dur_nxt = dur_cnt + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (sw_q != '0) begin
                    state_nxt = ST_MANUAL;
                    freq_nxt  = manual_f;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, input sample and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            sw_q        <= '0;
            armed       <= 1'b0;
            freq_q      <= '0;
            freq_update <= 1'b0;
            idx_q       <= '0;
            dur_cnt     <= '0;
        end else begin
            state       <= state_nxt;
            sw_q        <= switch;
            armed       <= 1'b1;
            freq_q      <= freq_nxt;
            freq_update <= (freq_nxt != freq_q);
            idx_q       <= idx_nxt;
            dur_cnt     <= dur_nxt;
        end
    end

    assign freq     = freq_q;
    assign playing  = (state == ST_PLAY);
    assign step_idx = idx_q;
`ifdef SEQ_LOOP_EN
    assign done = 1'b0;
`else
    assign done = (state == ST_HOLD);
`endif

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: directed scenarios followed by random switch
// and reset activity, every cycle compared with a timeline model that
// derives the current step from elapsed cycles since the play started.
// Honours SEQ_LOOP_EN the same way the design does.
module tb_tone_sequencer;

    localparam int TD    = 4;
    localparam int TOTAL = 4 * (20 + 6 + 4 + 2 + 1);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  sw = 4'd3;
    logic [15:0] freq;
    logic        freq_update, playing, done;
    logic [2:0]  step_idx;

    logic [9:0]  sw2 = 10'h3FF;
    logic [31:0] freq2;
    logic        fu2, pl2, dn2;
    logic [2:0]  si2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tone_sequencer #(.NUM_CH(2), .FREQ_W(8), .SW_W(4), .STEPS(5), .DUR_W(8), .TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .switch(sw), .freq(freq), .freq_update(freq_update),
        .playing(playing), .step_idx(step_idx), .done(done));

    tone_sequencer #(.NUM_CH(4), .FREQ_W(8), .SW_W(10), .STEPS(5), .DUR_W(8), .TICK_DIV(TD)) dut_w (
        .clk(clk), .reset(reset), .switch(sw2), .freq(freq2), .freq_update(fu2),
        .playing(pl2), .step_idx(si2), .done(dn2));

    // Reference table: {ch1, ch0} per step and durations in ticks
    logic [15:0] t_f [5] = '{16'h1414, 16'h1405, 16'h1401, 16'h1418, 16'h1414};
    int          t_d [5] = '{20, 6, 4, 2, 1};

    // Model state: mode 0 idle, 1 manual, 2 play, 3 hold
    int          m_mode = 0, m_start = 0, cyc = 0, m_idx = 0;
    bit          m_armed = 0, m_upd = 0;
    logic [3:0]  m_swq = 0;
    logic [15:0] m_f = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock edge of the abstract behaviour
    task automatic model_edge(input logic [3:0] s, input logic r);
        logic [3:0]  old;
        logic [15:0] nf;
        int n, k, acc;
        cyc++;
        if (r) begin
            m_mode = 0; m_swq = 0; m_armed = 0; m_f = 0; m_upd = 0; m_idx = 0;
            return;
        end
        old = m_swq;
        m_swq = s;
        nf = m_f;
        if (m_mode == 0) begin
            if (m_armed) begin
                if (old == 0) begin m_mode = 2; m_start = cyc; nf = t_f[0]; m_idx = 0; end
                else begin m_mode = 1; nf = {4'h0, old, 4'h0, old}; end
            end
        end else if (m_mode == 1 || m_mode == 3) begin
            if (old == 0 && m_mode == 1) begin
                m_mode = 2; m_start = cyc; nf = t_f[0]; m_idx = 0;
            end else if (old != 0) begin
                m_mode = 1; nf = {4'h0, old, 4'h0, old};
            end
        end else begin
            if (old != 0) begin
                m_mode = 1; nf = {4'h0, old, 4'h0, old}; m_idx = 0;
            end else begin
                n = cyc - m_start;
`ifdef SEQ_LOOP_EN
                n = n % TOTAL;
`endif
                if (n >= TOTAL) begin
                    m_mode = 3; m_idx = 0;
                end else begin
                    k = 0; acc = 0;
                    while (n >= acc + TD * t_d[k]) begin acc += TD * t_d[k]; k++; end
                    nf = t_f[k]; m_idx = k;
                end
            end
        end
        m_armed = 1;
        m_upd = (nf != m_f);
        m_f = nf;
    endtask

    // Advance one clock, update the model, compare all outputs
    task automatic tick_edge();
        logic [3:0] s;
        logic r;
        s = sw; r = reset;
        @(posedge clk);
        model_edge(s, r);
        #1;
        chk("freq", freq, m_f);
        chk("freq_update", freq_update, m_upd);
        chk("playing", playing, m_mode == 2);
        chk("step_idx", step_idx, m_idx);
`ifdef SEQ_LOOP_EN
        chk("done", done, 0);
`else
        chk("done", done, m_mode == 3);
`endif
    endtask

    task automatic seg_len(input logic [15:0] v, input int len, input string tag);
        int n;
        n = 0;
        while (freq === v && n < 300) begin n++; tick_edge(); end
        chk(tag, n, len);
    endtask

    initial begin
        int nupd, r, len;

        // 1: reset with switch=3, then manual after two edges with one pulse
        for (int i = 0; i < 3; i++) tick_edge();
        chk("rst_freq", freq, 0);
        chk("rst_freq_w", freq2, 0);
        reset = 1'b0;
        nupd = 0;
        for (int i = 1; i <= 12; i++) begin
            tick_edge();
            nupd += int'(freq_update);
            if (i == 1) chk("lat1_freq", freq, 0);
            if (i == 2) begin
                chk("man_freq", freq, 16'h0303);
                chk("trunc_freq_w", freq2, 32'hFFFF_FFFF);
            end
        end
        chk("man_pulses", nupd, 1);

        // 2: play the table from MANUAL
        sw = 4'd0;
        tick_edge(); tick_edge();
        chk("play_start", playing, 1);
        seg_len(16'h1414, 80, "len_step0");
        seg_len(16'h1405, 24, "len_step1");
        seg_len(16'h1401, 16, "len_step2");
        seg_len(16'h1418, 8, "len_step3");
        chk("step4_freq", freq, 16'h1414);
        chk("step4_idx", step_idx, 4);
        for (int i = 0; i < 4; i++) tick_edge();
`ifdef SEQ_LOOP_EN
        // 3: wrap to step 0
        chk("wrap_idx", step_idx, 0);
        chk("wrap_freq", freq, 16'h1414);
        chk("wrap_done", done, 0);
        chk("wrap_playing", playing, 1);
`else
        chk("hold_done", done, 1);
        chk("hold_freq", freq, 16'h1414);
        for (int i = 0; i < 20; i++) tick_edge();
        chk("hold_stays", done, 1);
`endif

        // 4: abort during step 1, then restart at step 0
        sw = 4'd9; tick_edge(); tick_edge();
        sw = 4'd0; tick_edge(); tick_edge();
        chk("restart_idx", step_idx, 0);
        for (int i = 0; i < 300 && step_idx !== 3'd1; i++) tick_edge();
        chk("reach_step1", step_idx, 1);
        tick_edge(); tick_edge();
        sw = 4'd9;
        tick_edge();
        chk("abort_lat1", playing, 1);
        tick_edge();
        chk("abort_freq", freq, 16'h0909);
        chk("abort_playing", playing, 0);
        sw = 4'd0; tick_edge(); tick_edge();
        chk("replay_freq", freq, 16'h1414);
        chk("replay_playing", playing, 1);

        // 5: reset during step 2
        for (int i = 0; i < 300 && step_idx !== 3'd2; i++) tick_edge();
        chk("reach_step2", step_idx, 2);
        tick_edge(); tick_edge(); tick_edge();
        reset = 1'b1;
        tick_edge();
        chk("midrst_freq", freq, 0);
        chk("midrst_playing", playing, 0);
        reset = 1'b0;
        tick_edge(); tick_edge();
        chk("postrst_freq", freq, 16'h1414);
        chk("postrst_idx", step_idx, 0);

        // 6: steady manual value gives no pulses; wide build truncates
        sw = 4'd5; sw2 = 10'h2A5;
        tick_edge(); tick_edge();
        chk("man5_freq", freq, 16'h0505);
        chk("trunc2_freq_w", freq2, 32'hA5A5_A5A5);
        nupd = 0;
        for (int i = 0; i < 10; i++) begin sw = 4'd5; tick_edge(); nupd += int'(freq_update); end
        chk("steady_pulses", nupd, 0);

        // Random switch/reset activity against the model
        for (int s = 0; s < 40; s++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin sw = 4'd0; len = $urandom_range(10, 160); end
            else if (r < 8) begin sw = 4'($urandom_range(1, 15)); len = $urandom_range(1, 12); end
            else if (r == 8) len = $urandom_range(2, 8);
            else begin reset = 1'b1; len = $urandom_range(1, 3); end
            for (int i = 0; i < len; i++) tick_edge();
            reset = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
